// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers, flat reg_out bus, per-register write pulses.
// Define AXIL_REG_SLAVE_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi_lite_reg_slave #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned NUM_REGS      = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLAVE_DECERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b11;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

    logic                     aw_held;
    logic                     w_held;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_W-1:0]        w_strb_q;
    logic                     awready_q;
    logic                     wready_q;
    logic                     bvalid_q;
    logic [1:0]               bresp_q;
    logic                     arready_q;
    logic                     rvalid_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [1:0]               rresp_q;
    logic [NUM_REGS-1:0]      wr_pulse_q;

    logic                     aw_hs;
    logic                     w_hs;
    logic                     ar_hs;
    logic                     aw_have;
    logic                     w_have;
    logic                     commit;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [STRB_W-1:0]        wr_strb;
    logic [ADDRESS_WIDTH-1:0] wr_word;
    logic                     wr_in_range;
    logic [IDX_W-1:0]         wr_idx;
    logic [ADDRESS_WIDTH-1:0] rd_word;
    logic                     rd_in_range;
    logic [IDX_W-1:0]         rd_idx;
    logic                     aw_held_n;
    logic                     w_held_n;
    logic                     bvalid_n;
    logic                     rvalid_n;
    logic                     unused_prot;

    assign unused_prot = ^{AWPROT, ARPROT};

    // Handshakes, held-or-arriving write halves, and address decode for both paths.
    always_comb begin
        aw_hs       = AWVALID && awready_q;
        w_hs        = WVALID && wready_q;
        ar_hs       = ARVALID && arready_q;
        aw_have     = aw_held || aw_hs;
        w_have      = w_held || w_hs;
        commit      = aw_have && w_have;
        wr_addr     = aw_held ? aw_addr_q : AWADDR;
        wr_data     = w_held ? w_data_q : WDATA;
        wr_strb     = w_held ? w_strb_q : WSTRB;
        wr_word     = wr_addr >> 2;
        wr_in_range = wr_word < ADDRESS_WIDTH'(NUM_REGS);
        wr_idx      = IDX_W'(wr_word);
        rd_word     = ARADDR >> 2;
        rd_in_range = rd_word < ADDRESS_WIDTH'(NUM_REGS);
        rd_idx      = IDX_W'(rd_word);
        aw_held_n   = aw_have && !commit;
        w_held_n    = w_have && !commit;
        bvalid_n    = commit || (bvalid_q && !BREADY);
        rvalid_n    = ar_hs || (rvalid_q && !RREADY);
    end

    // Write path: capture each half independently, commit once both are present.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse_q <= '0;
            aw_held    <= aw_held_n;
            w_held     <= w_held_n;
            if (aw_hs) begin
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (commit) begin
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_OOR;
                if (wr_in_range) begin
                    wr_pulse_q[wr_idx] <= 1'b1;
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
            end
            bvalid_q  <= bvalid_n;
            awready_q <= !aw_held_n && !bvalid_n;
            wready_q  <= !w_held_n && !bvalid_n;
        end
    end

    // Read path: sample pre-edge register contents on the AR handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rdata_q <= rd_in_range ? regs[rd_idx] : '0;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_OOR;
            end
            rvalid_q  <= rvalid_n;
            arready_q <= !rvalid_n;
        end
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign wr_pulse = wr_pulse_q;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed self-checking bench for axi_lite_reg_slave (8 x 32-bit registers).
module tb_axi_lite_reg_slave;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NR = 8;

`ifdef AXIL_REG_SLAVE_DECERR_EN
    localparam logic [1:0] EXP_OOR = 2'b11;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic              aclk = 1'b0;
    logic              areset;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NR*DW-1:0]  reg_out;
    logic [NR-1:0]     wr_pulse;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0]    exp_regs [NR];
    logic [NR*DW-1:0] exp_bus;
    logic [DW-1:0]    rd_d;
    logic [1:0]       rd_r;

    always #5 aclk = ~aclk;

    axi_lite_reg_slave #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR)) dut (
        .ACLK(aclk), .ARESET(areset),
        .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Full write with AW and W together and BREADY high; DUT must be idle on entry.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
        araddr = a; arvalid = 1'b1;
        step();
        d = rdata; r = rresp;
        arvalid = 1'b0; rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        step();
        step();
        n_cmp++; if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin
            n_err++; $display("FAIL rst_readys: got aw=%b w=%b ar=%b want 000", awready, wready, arready); end
        n_cmp++; if (bvalid !== 1'b0 || rvalid !== 1'b0 || wr_pulse !== '0) begin
            n_err++; $display("FAIL rst_valids: got b=%b r=%b pulse=%h want 0", bvalid, rvalid, wr_pulse); end
        n_cmp++; if (reg_out !== '0 || rdata !== '0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            n_err++; $display("FAIL rst_data: got reg_out=%h rdata=%h want 0", reg_out, rdata); end
        areset = 1'b0;
        step();
        n_cmp++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
            n_err++; $display("FAIL rel_readys: got aw=%b w=%b ar=%b want 111", awready, wready, arready); end
        araddr = '0; arvalid = 1'b1;
        step();
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b00 || arready !== 1'b0) begin
            n_err++; $display("FAIL rd0: got rvalid=%b rdata=%h rresp=%b arready=%b want 1 0 00 0", rvalid, rdata, rresp, arready); end
        arvalid = 1'b0; rready = 1'b1;
        step();
        rready = 1'b0;
        n_cmp++; if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_err++; $display("FAIL rd0_done: got rvalid=%b arready=%b want 0 1", rvalid, arready); end
    endtask

    task automatic test_write_same_cycle();
        awaddr = 32'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        exp_regs[1] = 32'hDEADBEEF;
        n_cmp++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_err++; $display("FAIL wr1_b: got bvalid=%b bresp=%b want 1 00", bvalid, bresp); end
        n_cmp++; if (reg_out[63:32] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL wr1_reg: got %h want deadbeef", reg_out[63:32]); end
        n_cmp++; if (wr_pulse !== 8'h02) begin
            n_err++; $display("FAIL wr1_pulse: got %h want 02", wr_pulse); end
        step();
        bready = 1'b0;
        n_cmp++; if (wr_pulse !== 8'h00 || bvalid !== 1'b0) begin
            n_err++; $display("FAIL wr1_after: got pulse=%h bvalid=%b want 00 0", wr_pulse, bvalid); end
    endtask

    task automatic test_w_before_aw();
        do_write(32'h8, 32'h11223344, 4'hF);
        wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        n_cmp++; if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            n_err++; $display("FAIL wheld: got wready=%b awready=%b bvalid=%b want 0 1 0", wready, awready, bvalid); end
        step();
        step();
        n_cmp++; if (wready !== 1'b0 || bvalid !== 1'b0 || reg_out[95:64] !== 32'h11223344) begin
            n_err++; $display("FAIL wheld2: got wready=%b bvalid=%b reg2=%h want 0 0 11223344", wready, bvalid, reg_out[95:64]); end
        awaddr = 32'h8; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        exp_regs[2] = 32'h112233AA;
        n_cmp++; if (bvalid !== 1'b1 || reg_out[95:64] !== 32'h112233AA || wr_pulse !== 8'h04) begin
            n_err++; $display("FAIL wpart: got bvalid=%b reg2=%h pulse=%h want 1 112233aa 04", bvalid, reg_out[95:64], wr_pulse); end
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic test_bready_backpressure();
        bready = 1'b0;
        awaddr = 32'hC; wdata = 32'h01010101; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        exp_regs[3] = 32'h01010101;
        awaddr = 32'h10; wdata = 32'h00000055;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d: got bvalid=%b aw=%b w=%b want 1 0 0", i, bvalid, awready, wready); end
            step();
        end
        n_cmp++; if (reg_out[159:128] !== 32'h0 || reg_out[127:96] !== 32'h01010101) begin
            n_err++; $display("FAIL bp_regs: got r4=%h r3=%h want 0 01010101", reg_out[159:128], reg_out[127:96]); end
        bready = 1'b1;
        step();
        bready = 1'b0;
        n_cmp++; if (bvalid !== 1'b0 || awready !== 1'b1 || reg_out[159:128] !== 32'h0) begin
            n_err++; $display("FAIL bp_bhs: got bvalid=%b awready=%b r4=%h want 0 1 0", bvalid, awready, reg_out[159:128]); end
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        exp_regs[4] = 32'h55;
        n_cmp++; if (bvalid !== 1'b1 || reg_out[159:128] !== 32'h55 || wr_pulse !== 8'h10) begin
            n_err++; $display("FAIL bp_second: got bvalid=%b r4=%h pulse=%h want 1 55 10", bvalid, reg_out[159:128], wr_pulse); end
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bready = 1'b1;
        awaddr = 32'h18; wdata = 32'hA5A50006; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        exp_regs[6] = 32'hA5A50006;
        n_cmp++; if (bvalid !== 1'b1 || awready !== 1'b0 || wr_pulse !== 8'h40) begin
            n_err++; $display("FAIL b2b_1: got bvalid=%b awready=%b pulse=%h want 1 0 40", bvalid, awready, wr_pulse); end
        awaddr = 32'h1C; wdata = 32'h5A5A0007;
        step();
        n_cmp++; if (bvalid !== 1'b0 || awready !== 1'b1 || wr_pulse !== 8'h00) begin
            n_err++; $display("FAIL b2b_gap: got bvalid=%b awready=%b pulse=%h want 0 1 00", bvalid, awready, wr_pulse); end
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        exp_regs[7] = 32'h5A5A0007;
        n_cmp++; if (bvalid !== 1'b1 || wr_pulse !== 8'h80 || reg_out[255:224] !== 32'h5A5A0007) begin
            n_err++; $display("FAIL b2b_2: got bvalid=%b pulse=%h r7=%h want 1 80 5a5a0007", bvalid, wr_pulse, reg_out[255:224]); end
        step();
        bready = 1'b0;
    endtask

    task automatic test_out_of_range();
        awaddr = 32'h20; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        n_cmp++; if (bvalid !== 1'b1 || bresp !== EXP_OOR || wr_pulse !== 8'h00) begin
            n_err++; $display("FAIL oor_wr: got bvalid=%b bresp=%b pulse=%h want 1 %b 00", bvalid, bresp, wr_pulse, EXP_OOR); end
        bready = 1'b1;
        step();
        bready = 1'b0;
        for (int i = 0; i < NR; i++) exp_bus[i*DW +: DW] = exp_regs[i];
        n_cmp++; if (reg_out !== exp_bus) begin
            n_err++; $display("FAIL oor_regs: got %h want %h", reg_out, exp_bus); end
        do_read(32'h20, rd_d, rd_r);
        n_cmp++; if (rd_d !== 32'h0 || rd_r !== EXP_OOR) begin
            n_err++; $display("FAIL oor_rd: got rdata=%h rresp=%b want 0 %b", rd_d, rd_r, EXP_OOR); end
        do_read(32'h1E, rd_d, rd_r);
        n_cmp++; if (rd_d !== 32'h5A5A0007 || rd_r !== 2'b00) begin
            n_err++; $display("FAIL rd7_unaligned: got rdata=%h rresp=%b want 5a5a0007 00", rd_d, rd_r); end
    endtask

    task automatic test_same_edge();
        do_write(32'h0, 32'h3, 4'hF);
        awaddr = 32'h0; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 32'h0; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h3) begin
            n_err++; $display("FAIL same_rd: got rvalid=%b rdata=%h want 1 3", rvalid, rdata); end
        n_cmp++; if (bvalid !== 1'b1 || reg_out[31:0] !== 32'h5 || wr_pulse !== 8'h01) begin
            n_err++; $display("FAIL same_wr: got bvalid=%b r0=%h pulse=%h want 1 5 01", bvalid, reg_out[31:0], wr_pulse); end
        rready = 1'b1;
        step();
        rready = 1'b0; bready = 1'b0;
        do_read(32'h0, rd_d, rd_r);
        n_cmp++; if (rd_d !== 32'h5 || rd_r !== 2'b00) begin
            n_err++; $display("FAIL same_reread: got rdata=%h rresp=%b want 5 00", rd_d, rd_r); end
    endtask

    task automatic test_reset_mid();
        bready = 1'b0;
        awaddr = 32'h14; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        n_cmp++; if (bvalid !== 1'b1 || reg_out[191:160] !== 32'h77) begin
            n_err++; $display("FAIL mid_wr: got bvalid=%b r5=%h want 1 77", bvalid, reg_out[191:160]); end
        areset = 1'b1;
        step();
        n_cmp++; if (bvalid !== 1'b0 || reg_out !== '0 || awready !== 1'b0 || wr_pulse !== '0) begin
            n_err++; $display("FAIL mid_rst: got bvalid=%b reg_out=%h awready=%b want 0 0 0", bvalid, reg_out, awready); end
        areset = 1'b0;
        step();
        n_cmp++; if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0) begin
            n_err++; $display("FAIL mid_rel: got aw=%b w=%b bvalid=%b want 1 1 0", awready, wready, bvalid); end
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_bready_backpressure();
        test_back_to_back();
        test_out_of_range();
        test_same_edge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
